// File: rtl/gf_pkg.sv
// Shared GF(2)[x] datapath definitions: divider FSM encoding, width helpers
// and the polynomial degree priority encoder.
package gf_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  // Widest polynomial the degree encoder accepts.
  localparam int GF_MAX_WIDTH = 64;

  function automatic int quot_width(input int dw);
    return 2 * dw;
  endfunction

  function automatic int cnt_width(input int dw);
    return $clog2(2 * dw + 1);
  endfunction

  // Index of the highest set coefficient; 0 for the zero polynomial.
  function automatic int poly_degree(input logic [GF_MAX_WIDTH-1:0] p);
    int deg;
    deg = 0;
    for (int i = 0; i < GF_MAX_WIDTH; i++) begin
      if (p[i]) deg = i;
    end
    return deg;
  endfunction

endpackage

// File: rtl/cl_div_step.sv
// One combinational step of GF(2)[x] long division: shift in the next
// dividend bit and reduce by the divisor when the degree-d coefficient is set.
module cl_div_step #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 5
) (
  input  logic [DATA_WIDTH-1:0] i_r,
  input  logic                  i_bit,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  input  logic [IDX_W-1:0]      i_deg,
  output logic [DATA_WIDTH-1:0] o_r,
  output logic                  o_q
);

  logic [DATA_WIDTH-1:0] w_t;

  // r stays below degree d, so dropping its MSB during the shift loses nothing.
  assign w_t = DATA_WIDTH'({i_r, i_bit});
  assign o_q = w_t[i_deg];
  assign o_r = o_q ? (w_t ^ i_divisor) : w_t;

endmodule

// File: rtl/cl_seq_div.sv
// Sequential carry-less polynomial divider: one quotient bit per clock,
// dividend consumed MSB-first, start/done handshake.
module cl_seq_div
  import gf_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [2*DATA_WIDTH-1:0] in_dividend,
  input  logic [DATA_WIDTH-1:0]   in_divisor,
  output logic                    busy,
  output logic                    done,
  output logic                    div_by_zero,
  output logic [2*DATA_WIDTH-1:0] out_quotient,
  output logic [DATA_WIDTH-1:0]   out_remainder
);

  localparam int QW     = quot_width(DATA_WIDTH);
  localparam int CW     = cnt_width(DATA_WIDTH);
  localparam int DW_IDX = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(QW - 1);

  div_state_e            r_state, w_state_next;
  logic [QW-1:0]         r_dividend, r_quot, r_out_quot;
  logic [DATA_WIDTH-1:0] r_divisor, r_rem, r_out_rem, w_rem_next;
  logic [DW_IDX-1:0]     r_deg, w_deg;
  logic [CW-1:0]         r_cnt;
  logic                  r_dz, w_q_bit, w_accept, w_last, w_zero_div;

  assign w_deg      = DW_IDX'(poly_degree(GF_MAX_WIDTH'(in_divisor)));
  assign w_zero_div = (in_divisor == '0);
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_last     = (r_cnt == LAST_STEP);

  cl_div_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (DW_IDX)
  ) u_step (
    .i_r       (r_rem),
    .i_bit     (r_dividend[QW-1]),
    .i_divisor (r_divisor),
    .i_deg     (r_deg),
    .o_r       (w_rem_next),
    .o_q       (w_q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = w_zero_div ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_deg      <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_cnt      <= '0;
      r_out_quot <= '0;
      r_out_rem  <= '0;
      r_dz       <= 1'b0;
    end else if (w_accept) begin
      r_dividend <= in_dividend;
      r_divisor  <= in_divisor;
      r_deg      <= w_deg;
      r_rem      <= '0;
      r_quot     <= '0;
      r_cnt      <= '0;
      r_dz       <= w_zero_div;
      // Divide by zero skips RUN, so its all-zero result is published here.
      if (w_zero_div) begin
        r_out_quot <= '0;
        r_out_rem  <= '0;
      end
    end else if (r_state == S_RUN) begin
      r_dividend <= r_dividend << 1;
      r_rem      <= w_rem_next;
      r_quot     <= {r_quot[QW-2:0], w_q_bit};
      r_cnt      <= r_cnt + 1'b1;
      if (w_last) begin
        r_out_quot <= {r_quot[QW-2:0], w_q_bit};
        r_out_rem  <= w_rem_next;
      end
    end
  end

  assign busy          = (r_state == S_RUN);
  assign done          = (r_state == S_DONE);
  assign div_by_zero   = r_dz;
  assign out_quotient  = r_out_quot;
  assign out_remainder = r_out_rem;

endmodule

// File: tb/tb_cl_seq_div.sv
// Directed-vector and random bench for cl_seq_div at DATA_WIDTH = 8,
// with a bit-serial long-division reference model.
module tb_cl_seq_div;

  localparam int DW = 8;
  localparam int QW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [QW-1:0] in_dividend = '0;
  logic [DW-1:0] in_divisor = '0;
  logic          busy, done, div_by_zero;
  logic [QW-1:0] out_quotient;
  logic [DW-1:0] out_remainder;

  int n_pass  = 0;
  int n_total = 0;

  cl_seq_div #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .busy          (busy),
    .done          (done),
    .div_by_zero   (div_by_zero),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [QW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic [QW-1:0] exp_q;
    logic [DW-1:0] exp_r;
    logic          exp_dz;
    int            exp_done;
    int            exp_busy;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int deg_of(input logic [DW-1:0] p);
    int d;
    d = -1;
    for (int i = 0; i < DW; i++) if (p[i]) d = i;
    return d;
  endfunction

  // Textbook long division on the full dividend, aligning the divisor under each set bit.
  task automatic ref_div(input logic [QW-1:0] dvd, input logic [DW-1:0] dvs,
                         output logic [QW-1:0] q, output logic [DW-1:0] r);
    logic [QW+DW-1:0] rem;
    int d;
    d   = deg_of(dvs);
    rem = {{DW{1'b0}}, dvd};
    q   = '0;
    for (int i = QW - 1; i >= d; i--) begin
      if (rem[i]) begin
        q[i-d] = 1'b1;
        rem    = rem ^ ({{QW{1'b0}}, dvs} << (i - d));
      end
    end
    r = rem[DW-1:0];
  endtask

  function automatic logic [31:0] clmul(input logic [QW-1:0] a, input logic [DW-1:0] b);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < DW; i++) if (b[i]) acc = acc ^ ({16'h0, a} << i);
    return acc;
  endfunction

  // Cycle 0 is the cycle in which start is sampled; sampling happens on negedges.
  task automatic do_op(input logic [QW-1:0] dvd, input logic [DW-1:0] dvs, input bit disturb,
                       output int done_cyc, output int busy_cnt,
                       output logic dz_c1, output logic [QW-1:0] q_mid);
    done_cyc = -1;
    busy_cnt = 0;
    dz_c1    = 1'b0;
    q_mid    = '0;
    @(negedge clk);
    check("done_low_before_start", {31'h0, done}, 32'h0);
    start       = 1'b1;
    in_dividend = dvd;
    in_divisor  = dvs;
    @(posedge clk);
    #1;
    start       = 1'b0;
    in_dividend = ~dvd;
    in_divisor  = ~dvs;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) dz_c1 = div_by_zero;
      if (c == 5) q_mid = out_quotient;
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        break;
      end
      if (disturb && c == 3) begin
        start       = 1'b1;
        in_dividend = 16'hFFFF;
        in_divisor  = 8'h80;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  vec_t          vecs[8];
  logic [QW-1:0] prev_q, q_mid, rq;
  logic [DW-1:0] rr;
  logic          dz_c1;
  int            done_cyc, busy_cnt, done_seen;

  initial begin
    vecs[0] = '{16'h0031, 8'h0B, 16'h0007, 8'h00, 1'b0, 17, 16};
    vecs[1] = '{16'h0032, 8'h0B, 16'h0007, 8'h03, 1'b0, 17, 16};
    vecs[2] = '{16'hBEEF, 8'h01, 16'hBEEF, 8'h00, 1'b0, 17, 16};
    vecs[3] = '{16'hFFFF, 8'h80, 16'h01FF, 8'h7F, 1'b0, 17, 16};
    vecs[4] = '{16'h1234, 8'h00, 16'h0000, 8'h00, 1'b1, 1, 0};
    vecs[5] = '{16'h00FF, 8'hFF, 16'h0001, 8'h00, 1'b0, 17, 16};
    vecs[6] = '{16'h0000, 8'h35, 16'h0000, 8'h00, 1'b0, 17, 16};
    vecs[7] = '{16'h0100, 8'h03, 16'h00FF, 8'h01, 1'b0, 17, 16};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_dz", {31'h0, div_by_zero}, 32'h0);
    check("reset_q", {16'h0, out_quotient}, 32'h0);
    check("reset_r", {24'h0, out_remainder}, 32'h0);
    rst_n = 1'b1;

    // Each op starts the cycle after the previous done, exercising back-to-back acceptance.
    prev_q = '0;
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].dividend, vecs[i].divisor, 1'b0, done_cyc, busy_cnt, dz_c1, q_mid);
      $display("op %0d: %h / %h -> q=%h r=%h dz=%b done@%0d busy=%0d",
               i, vecs[i].dividend, vecs[i].divisor, out_quotient, out_remainder,
               div_by_zero, done_cyc, busy_cnt);
      check("vec_done_cycle", done_cyc, vecs[i].exp_done);
      check("vec_busy_cycles", busy_cnt, vecs[i].exp_busy);
      check("vec_quotient", {16'h0, out_quotient}, {16'h0, vecs[i].exp_q});
      check("vec_remainder", {24'h0, out_remainder}, {24'h0, vecs[i].exp_r});
      check("vec_div_by_zero", {31'h0, div_by_zero}, {31'h0, vecs[i].exp_dz});
      check("vec_dz_cycle1", {31'h0, dz_c1}, {31'h0, vecs[i].exp_dz});
      if (vecs[i].exp_done == 17) check("vec_output_hold", {16'h0, q_mid}, {16'h0, prev_q});
      prev_q = vecs[i].exp_q;
    end

    // start with different operands pulsed mid-RUN must be ignored.
    do_op(16'h0032, 8'h0B, 1'b1, done_cyc, busy_cnt, dz_c1, q_mid);
    $display("op disturb: 0032 / 0b -> q=%h r=%h done@%0d", out_quotient, out_remainder, done_cyc);
    check("disturb_done_cycle", done_cyc, 17);
    check("disturb_quotient", {16'h0, out_quotient}, 32'h0007);
    check("disturb_remainder", {24'h0, out_remainder}, 32'h03);
    @(negedge clk);
    check("disturb_done_pulse", {31'h0, done}, 32'h0);
    check("disturb_no_restart", {31'h0, busy}, 32'h0);

    // Reset asserted in RUN cycle 5 aborts with cleared outputs and no done.
    start       = 1'b1;
    in_dividend = 16'hBEEF;
    in_divisor  = 8'h01;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_reset_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    $display("op reset-abort: q=%h r=%h busy=%b done=%b", out_quotient, out_remainder, busy, done);
    check("abort_q", {16'h0, out_quotient}, 32'h0);
    check("abort_r", {24'h0, out_remainder}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    for (int n = 0; n < 1000; n++) begin
      logic [QW-1:0] dvd;
      logic [DW-1:0] dvs;
      dvd = QW'($urandom);
      dvs = DW'($urandom_range(1, 255));
      ref_div(dvd, dvs, rq, rr);
      do_op(dvd, dvs, 1'b0, done_cyc, busy_cnt, dz_c1, q_mid);
      check("rand_done_cycle", done_cyc, 17);
      check("rand_quotient", {16'h0, out_quotient}, {16'h0, rq});
      check("rand_remainder", {24'h0, out_remainder}, {24'h0, rr});
      check("rand_identity", clmul(out_quotient, dvs) ^ {24'h0, out_remainder}, {16'h0, dvd});
      check("rand_rem_degree", {24'h0, out_remainder >> deg_of(dvs)}, 32'h0);
    end
    $display("random: 1000 ops issued");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
